// File: rtl/softmax_max_stage.sv
// Softmax max stage: buffers one logit vector while tracking its maximum,
// then replays every element in order paired with that maximum.
module softmax_max_stage #(
    parameter int VEC_LEN = 10,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [31:0] out_max,
    output logic        out_last,
    output logic        busy
);

    typedef enum logic {LOAD, EMIT} state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wr_cnt, rd_cnt;
    logic [31:0]      max_q;
    logic [31:0]      mem [VEC_LEN];
    logic             in_hs, out_hs, wr_last, rd_last, take_max;

    // Maps IEEE-754 bit patterns onto an unsigned key with the same ordering.
    function automatic logic [31:0] key(input logic [31:0] x);
        return x[31] ? ~x : (x ^ 32'h8000_0000);
    endfunction

    always_comb begin
        in_ready  = (state == LOAD);
        out_valid = (state == EMIT);
        busy      = out_valid;
        in_hs     = in_valid & in_ready;
        out_hs    = out_valid & out_ready;
        wr_last   = (wr_cnt == LAST_IDX);
        rd_last   = (rd_cnt == LAST_IDX);
        out_last  = out_valid & rd_last;
        out_data  = mem[rd_cnt];
        out_max   = max_q;
        // Strictly greater keeps the first of equal maxima.
        take_max  = (wr_cnt == '0) || (key(in_data) > key(max_q));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (in_hs && wr_last)   state_nxt = EMIT;
            EMIT:    if (out_hs && rd_last)  state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state  <= LOAD;
            wr_cnt <= '0;
            rd_cnt <= '0;
            max_q  <= '0;
        end else begin
            state <= state_nxt;
            if (in_hs) begin
                wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
                if (take_max) max_q <= in_data;
            end
            if (out_hs) rd_cnt <= rd_last ? '0 : rd_cnt + 1'b1;
        end
    end

    // Vector storage carries no reset; contents are always rewritten before replay.
    always_ff @(posedge clk) begin
        if (in_hs) mem[wr_cnt] <= in_data;
    end

endmodule

// File: tb/tb_softmax_max_stage.sv
// Scoreboard bench for softmax_max_stage with VEC_LEN=4 directed vectors.
module tb_softmax_max_stage;

    localparam int VL = 4;
    localparam int CW = 2;

    logic        clk = 1'b0;
    logic        areset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [31:0] out_max;
    logic        out_last;
    logic        busy;

    softmax_max_stage #(.VEC_LEN(VL), .CNT_W(CW)) dut (
        .clk(clk), .areset(areset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_max(out_max), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] mx;
        logic        last;
    } exp_t;
    typedef logic [31:0] vec_t [VL];

    exp_t q[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    vec_t vec;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: compares the presented beat against the scoreboard head;
    // a stalled beat is re-checked each cycle, so it must hold steady.
    always @(negedge clk) begin
        if (areset && out_valid) begin
            if (q.size() == 0) begin
                check("unexpected_beat", 32'(out_valid), 32'd0);
            end else begin
                check("out_data", out_data, q[0].data);
                check("out_max", out_max, q[0].mx);
                check("out_last", 32'(out_last), 32'(q[0].last));
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic send_vec(input vec_t v, input logic [31:0] mx);
        for (int i = 0; i < VL; i++) begin
            in_valid = 1'b1;
            in_data  = v[i];
            q.push_back('{data: v[i], mx: mx, last: (i == VL - 1)});
            wait_ready();
            if (i == VL - 1) check("pre_last_out_valid", 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("lat_out_valid", 32'(out_valid), 32'd1);
        check("lat_busy", 32'(busy), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() > 0 || out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) check("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    initial begin
        logic [3:0] pat;
        int         k;

        // Reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        @(negedge clk);
        areset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Basic
        out_ready = 1'b1;
        vec = '{32'h3F800000, 32'h40400000, 32'hC0000000, 32'h40000000};
        send_vec(vec, 32'h40400000);
        drain();

        // All negative
        vec = '{32'hBF800000, 32'hBF000000, 32'hC0400000, 32'hC0000000};
        send_vec(vec, 32'hBF000000);
        drain();

        // Signed zeros, then ties
        vec = '{32'h80000000, 32'h00000000, 32'h00000000, 32'h80000000};
        send_vec(vec, 32'h00000000);
        drain();
        vec = '{32'h3F800000, 32'h3F000000, 32'h3F800000, 32'hBF800000};
        send_vec(vec, 32'h3F800000);
        drain();

        // Backpressure, with in_valid held high during EMIT carrying a huge value
        vec = '{32'h40A00000, 32'hC1200000, 32'h41000000, 32'h3E800000};
        send_vec(vec, 32'h41000000);
        pat = 4'b1001;
        k = 0;
        in_valid = 1'b1;
        in_data  = 32'h7F000000;
        while (q.size() > 0 && k < 100) begin
            out_ready = pat[k % 4];
            @(negedge clk);
            if (out_valid) check("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            k++;
        end
        in_valid = 1'b0;
        if (k >= 100) check("bp_timeout", 32'(q.size()), 32'd0);
        check("bp_in_ready_after", 32'(in_ready), 32'd1);
        check("bp_out_valid_after", 32'(out_valid), 32'd0);
        out_ready = 1'b1;

        // Back-to-back vectors
        vec = '{32'h3F800000, 32'h40400000, 32'hC0000000, 32'h40000000};
        send_vec(vec, 32'h40400000);
        vec = '{32'hBF800000, 32'hBF800000, 32'hBF800000, 32'hBF800000};
        send_vec(vec, 32'hBF800000);
        drain();

        // Reset mid-EMIT after two output beats
        vec = '{32'h40A00000, 32'hC1200000, 32'h41000000, 32'h3E800000};
        send_vec(vec, 32'h41000000);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("pre_rst_q_left", 32'(q.size()), 32'd2);
        areset = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_out_last", 32'(out_last), 32'd0);
        q.delete();
        @(negedge clk);
        areset = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        vec = '{32'h41200000, 32'hC1A00000, 32'h40E00000, 32'h41100000};
        send_vec(vec, 32'h41200000);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
